// File: rtl/display_arbiter.sv
// display_arbiter: shares the display unit's write port between two
// character-stream requesters. Each message is sequenced as buffer clear,
// character pushes, print strobe, then CSR re-arm. The owner holds the
// display until its message completes.
`timescale 1ns/1ps
module display_arbiter #(
    parameter int unsigned MAX_CHARS = 127
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_valid_i,
    input  logic [15:0] req_data_i,
    input  logic [1:0]  req_last_i,
    output logic [1:0]  req_ready_o,
    output logic [3:0]  du_addr_o,
    output logic [31:0] du_wdata_o,
    output logic        du_wr_en_o,
    input  logic        du_stall_i,
    output logic [1:0]  grant_o,
    output logic        busy_o
);

    localparam int unsigned CNT_W = $clog2(MAX_CHARS + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CHARS);
    localparam logic [3:0]  ADDR_CSR  = 4'h8;
    localparam logic [3:0]  ADDR_BUF  = 4'hC;
    localparam logic [31:0] CSR_CLEAR = 32'h0000_0001;
    localparam logic [31:0] CSR_PRINT = 32'h0000_0002;
    localparam logic [31:0] CSR_REARM = 32'h0000_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_PRINT,
        S_REARM
    } state_t;

    state_t           state;
    logic             owner;     // index of the granted requester
    logic             rr_ptr;    // requester with priority at the next grant
    logic [CNT_W-1:0] count;     // non-NUL characters in the current load
    logic             cont;      // current load was a forced flush, message continues

    logic             pick;
    logic [7:0]       cur_byte;
    logic             cur_valid;
    logic             cur_last;
    logic             cur_nul;
    logic             stream_rdy;
    logic             accept;
    logic             write_done;
    logic [CNT_W-1:0] count_inc;

    // Selection of the owner's stream and the handshake qualifiers.
    assign pick       = req_valid_i[rr_ptr] ? rr_ptr : ~rr_ptr;
    assign cur_byte   = owner ? req_data_i[15:8] : req_data_i[7:0];
    assign cur_valid  = req_valid_i[owner];
    assign cur_last   = req_last_i[owner];
    assign cur_nul    = (cur_byte == 8'h00);
    assign stream_rdy = (state == S_STREAM) && !du_stall_i && (count < MAX_CNT);
    assign accept     = stream_rdy && cur_valid;
    assign write_done = du_wr_en_o && !du_stall_i;
    assign count_inc  = count + CNT_W'(1);
    assign busy_o     = (state != S_IDLE);

    // Display-unit command and requester ready decoded from the current state.
    always_comb begin
        req_ready_o = 2'b00;
        du_addr_o   = 4'h0;
        du_wdata_o  = 32'h0;
        du_wr_en_o  = 1'b0;
        unique case (state)
            S_CLEAR: begin
                du_addr_o  = ADDR_CSR;
                du_wdata_o = CSR_CLEAR;
                du_wr_en_o = 1'b1;
            end
            S_STREAM: begin
                req_ready_o = owner ? {stream_rdy, 1'b0} : {1'b0, stream_rdy};
                du_addr_o   = ADDR_BUF;
                du_wdata_o  = {24'h0, cur_byte};
                du_wr_en_o  = accept && !cur_nul;
            end
            S_PRINT: begin
                if (count != '0) begin
                    du_addr_o  = ADDR_CSR;
                    du_wdata_o = CSR_PRINT;
                    du_wr_en_o = 1'b1;
                end
            end
            S_REARM: begin
                du_addr_o  = ADDR_CSR;
                du_wdata_o = CSR_REARM;
                du_wr_en_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Message sequencer: arbitration, load counting and continuation loads.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            grant_o <= 2'b00;
            owner   <= 1'b0;
            rr_ptr  <= 1'b0;
            count   <= '0;
            cont    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (|req_valid_i) begin
                        owner   <= pick;
                        rr_ptr  <= ~pick;
                        grant_o <= pick ? 2'b10 : 2'b01;
                        state   <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (write_done) begin
                        count <= '0;
                        state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (accept) begin
                        if (!cur_nul) begin
                            count <= count_inc;
                        end
                        if (cur_last || (!cur_nul && (count_inc == MAX_CNT))) begin
                            cont  <= ~cur_last;
                            state <= S_PRINT;
                        end
                    end
                end
                S_PRINT: begin
                    // An all-NUL load has nothing to print and moves on without a write.
                    if (write_done || ((count == '0) && !du_stall_i)) begin
                        state <= S_REARM;
                    end
                end
                S_REARM: begin
                    if (write_done) begin
                        if (cont) begin
                            state <= S_CLEAR;
                        end else begin
                            grant_o <= 2'b00;
                            state   <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
